// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced key transitions into a stream of key events.
//
// Each key runs a small press/long-press FSM. Generated events land in a
// one-entry pending register per key; a round-robin arbiter moves at most one
// pending event per cycle into a show-ahead FIFO read by the consumer.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   key_flag   in   [NKEY]  one-cycle pulse per debounced transition
//   key_state  in   [NKEY]  debounced level, 0 = pressed, 1 = released
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   consumer takes the head when evt_valid && evt_ready
//   evt_key    out  [clog2(NKEY)] key index of head event (0 when empty)
//   evt_type   out  [2] 00 PRESS, 01 SHORT_REL, 10 LONG_REL, 11 HOLD (0 when empty)
//   overflow   out  sticky, an event was dropped; cleared only by reset

// Per-key FSM: IDLE -> PRESSED -> (LONG) -> IDLE, one event per transition.
module key_event_fsm #(
    parameter int LONG_CNT = 25_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       flag_i,
    input  logic       level_i,
    output logic       evt_vld_o,
    output logic [1:0] evt_type_o
);
    localparam int             TW   = $clog2(LONG_CNT);
    localparam logic [TW-1:0]  TMAX = TW'(LONG_CNT - 1);

    localparam logic [1:0] EV_PRESS = 2'b00;
    localparam logic [1:0] EV_SREL  = 2'b01;
    localparam logic [1:0] EV_LREL  = 2'b10;
    localparam logic [1:0] EV_HOLD  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        evt_vld_o  = 1'b0;
        evt_type_o = EV_PRESS;
        case (state_q)
            S_IDLE: begin
                if (flag_i && !level_i) begin
                    state_d   = S_PRESSED;
                    tmr_d     = '0;
                    evt_vld_o = 1'b1;
                end
            end
            S_PRESSED: begin
                // A release in the same cycle the timer expires wins: the key
                // was never held for the full long-press time.
                if (flag_i && level_i) begin
                    state_d    = S_IDLE;
                    evt_vld_o  = 1'b1;
                    evt_type_o = EV_SREL;
                end else if (tmr_q == TMAX) begin
                    state_d    = S_LONG;
                    evt_vld_o  = 1'b1;
                    evt_type_o = EV_HOLD;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_LONG: begin
                // Timer stays parked at TMAX here, so it can never wrap.
                if (flag_i && level_i) begin
                    state_d    = S_IDLE;
                    evt_vld_o  = 1'b1;
                    evt_type_o = EV_LREL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

module key_event_ctrl #(
    parameter int NKEY     = 4,
    parameter int LONG_CNT = 25_000_000,
    parameter int DEPTH    = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NKEY-1:0]         key_flag,
    input  logic [NKEY-1:0]         key_state,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(NKEY)-1:0] evt_key,
    output logic [1:0]              evt_type,
    output logic                    overflow
);
    localparam int KW = $clog2(NKEY);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [KW-1:0] key;
        logic [1:0]    typ;
    } evt_t;

    logic [NKEY-1:0]       evt_vld;
    logic [NKEY-1:0][1:0]  evt_type_w;

    logic [NKEY-1:0]       pend_vld_q, pend_vld_d;
    logic [NKEY-1:0][1:0]  pend_type_q, pend_type_d;
    logic [KW-1:0]         ptr_q, ptr_d;
    logic                  ovf_q, ovf_d;

    evt_t [DEPTH-1:0]      mem_q;
    logic [AW:0]           wr_q, rd_q;
    logic                  empty, full, pop;
    logic                  gnt_vld;
    logic [KW-1:0]         gnt_idx;
    evt_t                  head;

    key_event_fsm #(.LONG_CNT(LONG_CNT)) u_fsm [NKEY-1:0] (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .flag_i     (key_flag),
        .level_i    (key_state),
        .evt_vld_o  (evt_vld),
        .evt_type_o (evt_type_w)
    );

    function automatic logic [KW-1:0] rr_idx(input logic [KW-1:0] base, input int off);
        return KW'((int'(base) + off) % NKEY);
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && evt_ready;

    // Round-robin search starting at ptr_q. A pop this cycle frees a slot even
    // when full, so the grant may proceed.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!full || pop) begin
            for (int off = 0; off < NKEY; off++) begin
                if (!gnt_vld && pend_vld_q[rr_idx(ptr_q, off)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx(ptr_q, off);
                end
            end
        end
    end

    // Grant clears first, so a slot drained this cycle can take a new event.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_type_d = pend_type_q;
        ovf_d       = ovf_q;
        if (gnt_vld) pend_vld_d[gnt_idx] = 1'b0;
        for (int k = 0; k < NKEY; k++) begin
            if (evt_vld[k]) begin
                if (pend_vld_d[k]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_vld_d[k]  = 1'b1;
                    pend_type_d[k] = evt_type_w[k];
                end
            end
        end
        ptr_d = gnt_vld ? rr_idx(gnt_idx, 1) : ptr_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_vld_q  <= '0;
            pend_type_q <= '0;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            mem_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_type_q <= pend_type_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            // On full+pop the write reuses the slot being read out this edge.
            if (gnt_vld) begin
                mem_q[wr_q[AW-1:0]] <= {gnt_idx, pend_type_q[gnt_idx]};
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    assign head      = mem_q[rd_q[AW-1:0]];
    assign evt_valid = !empty;
    assign evt_key   = empty ? '0 : head.key;
    assign evt_type  = empty ? '0 : head.typ;
    assign overflow  = ovf_q;
endmodule
